aes_key_expand_gen: RTL and testbench

- Word-serial AES key-schedule generator for AES-128/192/256, selected at run time.
- Loads a cipher key on a start pulse and produces round keys 0..Nr as 128-bit words, in order, over a valid/ready stream.
- Generates rcon internally and applies backpressure to itself when the consumer stalls.
- Feeds the round datapath in place of the fixed 128-bit single-step key expander; instantiates 4 copies of the existing SBOX module.

---
 rtl/aes_key_expand_gen.sv | 261 ++++++++++++++++++++++++++
 tb/tb_aes_key_expand_gen.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_gen.sv
// Word-serial AES-128/192/256 key schedule generator: produces one 32-bit schedule
// word per cycle and emits round keys 0..Nr as 128-bit words over a valid/ready stream.

module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    // Forward AES S-box; entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byte_o = SBOX_TABLE[{~byte_i, 3'b000} +: 8];
endmodule

module aes_key_expand_gen #(
    parameter int MAX_KEY_BITS = 256,
    parameter int HIST_WORDS   = MAX_KEY_BITS / 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              key_size,
    input  logic [MAX_KEY_BITS-1:0] key_in,
    input  logic                    flush,
    output logic [127:0]            out_key,
    output logic [3:0]              out_round,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    err
);
    localparam bit FITS_192 = (MAX_KEY_BITS >= 192);
    localparam bit FITS_256 = (MAX_KEY_BITS >= 256);

    typedef enum logic {ST_IDLE, ST_GEN} state_e;

    state_e                  state_q, state_d;
    logic [MAX_KEY_BITS-1:0] key_q, key_d;
    logic [31:0]             hist_q [HIST_WORDS];
    logic [31:0]             hist_d [HIST_WORDS];
    logic [31:0]             col_q [3];
    logic [31:0]             col_d [3];
    logic [1:0]              col_cnt_q, col_cnt_d;
    logic [5:0]              idx_q, idx_d;
    logic [2:0]              phase_q, phase_d;
    logic [3:0]              nk_q, nk_d;
    logic [3:0]              nr_q, nr_d;
    logic [7:0]              rcon_q, rcon_d;
    logic [3:0]              load_round_q, load_round_d;
    logic [127:0]            out_key_q, out_key_d;
    logic [3:0]              out_round_q, out_round_d;
    logic                    out_last_q, out_last_d;
    logic                    out_valid_q, out_valid_d;
    logic                    err_q, err_d;

    logic [3:0]  req_nk, req_nr;
    logic        req_legal;
    logic [5:0]  words_total;
    logic        in_key_phase, rot_step, sub_step;
    logic [31:0] prev_word, back_word, sub_in, sub_out, t_word, new_word;
    logic        out_accept, out_free, gen_active, produce, load_out;

    always_comb begin
        req_nk    = 4'd4;
        req_nr    = 4'd10;
        req_legal = 1'b1;
        unique case (key_size)
            2'd0: begin
                req_nk = 4'd4;
                req_nr = 4'd10;
            end
            2'd1: begin
                req_nk    = 4'd6;
                req_nr    = 4'd12;
                req_legal = FITS_192;
            end
            2'd2: begin
                req_nk    = 4'd8;
                req_nr    = 4'd14;
                req_legal = FITS_256;
            end
            default: req_legal = 1'b0;
        endcase
    end

    // phase_q tracks i mod Nk so no divider is needed on the word index.
    assign words_total  = {nr_q + 4'd1, 2'b00};
    assign in_key_phase = (idx_q < {2'b00, nk_q});
    assign rot_step     = (phase_q == 3'd0);
    assign sub_step     = (nk_q == 4'd8) && (phase_q == 3'd4);
    assign prev_word    = hist_q[0];
    assign sub_in       = rot_step ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    always_comb begin
        back_word = '0;
        for (int k = 0; k < HIST_WORDS; k++) begin
            if (4'(k) == nk_q - 4'd1) back_word = hist_q[k];
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_i (sub_in[8*b +: 8]),
            .byte_o (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        if (rot_step)      t_word = sub_out ^ {rcon_q, 24'h000000};
        else if (sub_step) t_word = sub_out;
        else               t_word = prev_word;
        new_word = in_key_phase ? key_q[MAX_KEY_BITS-1 -: 32] : (back_word ^ t_word);
    end

    assign out_accept = out_valid_q && out_ready;
    assign out_free   = !out_valid_q || out_ready;
    assign gen_active = (state_q == ST_GEN) && (idx_q != words_total);
    // The 4th word of a key may only be produced when the output register can take it.
    assign produce    = gen_active && ((col_cnt_q != 2'd3) || out_free);
    assign load_out   = produce && (col_cnt_q == 2'd3);

    always_comb begin
        // NOTE: every next-state value defaults to its register so no branch infers a latch.
        state_d      = state_q;
        key_d        = key_q;
        hist_d       = hist_q;
        col_d        = col_q;
        col_cnt_d    = col_cnt_q;
        idx_d        = idx_q;
        phase_d      = phase_q;
        nk_d         = nk_q;
        nr_d         = nr_q;
        rcon_d       = rcon_q;
        load_round_d = load_round_q;
        out_key_d    = out_key_q;
        out_round_d  = out_round_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        err_d        = 1'b0;

        if (produce) begin
            key_d     = key_q << 32;
            hist_d[0] = new_word;
            for (int k = 1; k < HIST_WORDS; k++) hist_d[k] = hist_q[k-1];
            idx_d   = idx_q + 6'd1;
            phase_d = ({1'b0, phase_q} == nk_q - 4'd1) ? 3'd0 : phase_q + 3'd1;
            if (!in_key_phase && rot_step) begin
                rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
            if (load_out) begin
                out_key_d    = {col_q[0], col_q[1], col_q[2], new_word};
                out_round_d  = load_round_q;
                out_last_d   = (load_round_q == nr_q);
                out_valid_d  = 1'b1;
                load_round_d = load_round_q + 4'd1;
                col_cnt_d    = 2'd0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (2'(k) == col_cnt_q) col_d[k] = new_word;
                end
                col_cnt_d = col_cnt_q + 2'd1;
            end
        end

        if (out_accept && !load_out) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (out_accept && out_last_q) state_d = ST_IDLE;

        if (start && (state_q == ST_IDLE)) begin
            if (req_legal) begin
                state_d      = ST_GEN;
                key_d        = key_in;
                nk_d         = req_nk;
                nr_d         = req_nr;
                idx_d        = 6'd0;
                phase_d      = 3'd0;
                rcon_d       = 8'h01;
                col_cnt_d    = 2'd0;
                load_round_d = 4'd0;
            end else begin
                err_d = 1'b1;
            end
        end

        if (flush) begin
            state_d     = ST_IDLE;
            col_cnt_d   = 2'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_key_d   = '0;
            out_round_d = 4'd0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: history and collector are cleared too, so no stale word survives a reset.
            state_q <= ST_IDLE;
            key_q   <= '0;
            for (int k = 0; k < HIST_WORDS; k++) hist_q[k] <= '0;
            for (int k = 0; k < 3; k++) col_q[k] <= '0;
            col_cnt_q    <= 2'd0;
            idx_q        <= 6'd0;
            phase_q      <= 3'd0;
            nk_q         <= 4'd0;
            nr_q         <= 4'd0;
            rcon_q       <= 8'h01;
            load_round_q <= 4'd0;
            out_key_q    <= '0;
            out_round_q  <= 4'd0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            key_q        <= key_d;
            hist_q       <= hist_d;
            col_q        <= col_d;
            col_cnt_q    <= col_cnt_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            nk_q         <= nk_d;
            nr_q         <= nr_d;
            rcon_q       <= rcon_d;
            load_round_q <= load_round_d;
            out_key_q    <= out_key_d;
            out_round_q  <= out_round_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            err_q        <= err_d;
        end
    end

    assign out_key   = out_key_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_GEN);
    assign err       = err_q;
endmodule

// File: tb/tb_aes_key_expand_gen.sv
// Self-checking bench for aes_key_expand_gen: a FIPS-197 key schedule model built from
// GF(2^8) arithmetic predicts every round key; stimulus uses random keys and backpressure.

module tb_aes_key_expand_gen;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         start = 1'b0;
    logic [1:0]   key_size = 2'd0;
    logic [255:0] key_in = '0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         out_last, out_valid, busy, err;

    logic         start_s = 1'b0;
    logic [1:0]   key_size_s = 2'd0;
    logic [127:0] key_in_s = '0;
    logic         flush_s = 1'b0;
    logic         out_ready_s = 1'b0;
    logic [127:0] out_key_s;
    logic [3:0]   out_round_s;
    logic         out_last_s, out_valid_s, busy_s, err_s;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_keys [15];
    logic [127:0] got_keys [15];
    int           exp_nr = 10;

    aes_key_expand_gen #(.MAX_KEY_BITS(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_size(key_size), .key_in(key_in),
        .flush(flush), .out_key(out_key), .out_round(out_round), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
    );

    aes_key_expand_gen #(.MAX_KEY_BITS(128)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .key_size(key_size_s), .key_in(key_in_s),
        .flush(flush_s), .out_key(out_key_s), .out_round(out_round_s), .out_last(out_last_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .busy(busy_s), .err(err_s)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic build_model(input logic [255:0] k, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc     = 8'h01;
        exp_nr = nk + 6;
        for (int i = 0; i < 4 * (exp_nr + 1); i++) begin
            if (i < nk) begin
                w[i] = k[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= exp_nr; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic start_key(input logic [1:0] sz, input logic [255:0] k);
        key_size = sz;
        key_in   = k;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Consumes the whole stream, checking every key against the model and hold stability.
    task automatic collect(input int ready_pct, input int hold_round);
        int           n = 0;
        int           cycles = 0;
        int           hold_left = 0;
        bit           hold_done = 1'b0;
        bit           stalled = 1'b0;
        logic [127:0] last_key = '0;
        while (n <= exp_nr && cycles < 2000) begin
            if (!hold_done && hold_round >= 0 && out_valid && out_round == 4'(hold_round)) begin
                hold_left = 10;
                hold_done = 1'b1;
            end
            if (hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = (int'($urandom_range(0, 99)) < ready_pct);
            end
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_key !== last_key) begin
                    n_bad++;
                    $display("FAIL stall_hold: valid=%b key=%h, expected valid=1 key=%h", out_valid, out_key, last_key);
                end
            end
            if (out_valid && out_ready) begin
                got_keys[n] = out_key;
                n_cmp++;
                if (out_key !== exp_keys[n]) begin
                    n_bad++;
                    $display("FAIL key_round%0d: got %h, expected %h", n, out_key, exp_keys[n]);
                end
                n_cmp++;
                if (out_round !== 4'(n) || out_last !== (n == exp_nr)) begin
                    n_bad++;
                    $display("FAIL round_tag%0d: round=%0d last=%b, expected round=%0d last=%b",
                             n, out_round, out_last, n, (n == exp_nr));
                end
                n++;
            end
            stalled  = out_valid && !out_ready;
            last_key = out_key;
            @(posedge clk); #1;
            cycles++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (n <= exp_nr) begin
            n_bad++;
            $display("FAIL stream_timeout: got %0d keys, expected %0d", n, exp_nr + 1);
        end else if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL end_idle: busy=%b valid=%b, expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, busy, err, out_last} !== 4'b0000 || out_key !== '0 || out_round !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_main: valid=%b busy=%b err=%b last=%b round=%0d key=%h, expected all 0",
                     out_valid, busy, err, out_last, out_round, out_key);
        end
        n_cmp++;
        if ({out_valid_s, busy_s, err_s, out_last_s} !== 4'b0000 || out_key_s !== '0) begin
            n_bad++;
            $display("FAIL reset_small: valid=%b busy=%b err=%b, expected all 0", out_valid_s, busy_s, err_s);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_aes128();
        logic [255:0] k;
        int           cnt = 0;
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, $urandom(), $urandom(), $urandom(), $urandom()};
        build_model(k, 4);
        start_key(2'd0, k);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_after_start: got %b, expected 1", busy);
        end
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_cmp++;
        if (cnt != 4) begin
            n_bad++;
            $display("FAIL first_latency: got %0d cycles, expected 4", cnt);
        end
        collect(100, -1);
        n_cmp++;
        if (got_keys[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_bad++;
            $display("FAIL aes128_round1: got %h, expected a0fafe1788542cb123a339392a6c7605", got_keys[1]);
        end
        n_cmp++;
        if (got_keys[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_bad++;
            $display("FAIL aes128_round10: got %h, expected d014f9a8c9ee2589e13f0cc8b6630ca6", got_keys[10]);
        end
    endtask

    task automatic test_aes192();
        logic [255:0] k;
        k = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, $urandom(), $urandom()};
        build_model(k, 6);
        start_key(2'd1, k);
        collect(100, -1);
        n_cmp++;
        if (got_keys[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
            n_bad++;
            $display("FAIL aes192_round12: got %h, expected e98ba06f448c773c8ecc720401002202", got_keys[12]);
        end
    endtask

    task automatic test_aes256();
        logic [255:0] k;
        k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        build_model(k, 8);
        start_key(2'd2, k);
        collect(100, -1);
        n_cmp++;
        if (got_keys[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            n_bad++;
            $display("FAIL aes256_round14: got %h, expected fe4890d1e6188d0b046df344706c631e", got_keys[14]);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] k;
        k = rand256();
        build_model(k, 4);
        start_key(2'd0, k);
        collect(50, 3);
    endtask

    task automatic test_illegal();
        bit quiet = 1'b1;
        start_key(2'd3, rand256());
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_size3: err=%b busy=%b, expected 1 0", err, busy);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL illegal_quiet: err=%b busy=%b valid=%b, expected 0 0 0", err, busy, out_valid);
        end
        key_size_s = 2'd2;
        key_in_s   = rand256()[127:0];
        start_s    = 1'b1;
        @(posedge clk); #1;
        start_s    = 1'b0;
        n_cmp++;
        if (err_s !== 1'b1 || busy_s !== 1'b0 || out_valid_s !== 1'b0) begin
            n_bad++;
            $display("FAIL small_size256: err=%b busy=%b valid=%b, expected 1 0 0", err_s, busy_s, out_valid_s);
        end
        key_size_s = 2'd0;
        start_s    = 1'b1;
        @(posedge clk); #1;
        start_s    = 1'b0;
        n_cmp++;
        if (err_s !== 1'b0 || busy_s !== 1'b1) begin
            n_bad++;
            $display("FAIL small_size128: err=%b busy=%b, expected 0 1", err_s, busy_s);
        end
        flush_s = 1'b1;
        @(posedge clk); #1;
        flush_s = 1'b0;
        n_cmp++;
        if (busy_s !== 1'b0 || out_valid_s !== 1'b0) begin
            n_bad++;
            $display("FAIL small_flush: busy=%b valid=%b, expected 0 0", busy_s, out_valid_s);
        end
    endtask

    task automatic test_start_during_busy();
        logic [255:0] k;
        k = rand256();
        build_model(k, 4);
        start_key(2'd0, k);
        @(posedge clk); #1;
        start_key(2'd2, rand256());
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_while_busy: err=%b busy=%b, expected 0 1", err, busy);
        end
        collect(100, -1);
    endtask

    task automatic test_flush_restart();
        logic [255:0] k_new;
        int           cnt = 0;
        k_new = rand256();
        start_key(2'd0, rand256());
        out_ready = 1'b1;
        while (!(out_valid && out_round == 4'd5) && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (cnt >= 200) begin
            n_bad++;
            $display("FAIL flush_wait_timeout: round=%0d valid=%b, expected round 5 valid", out_round, out_valid);
        end
        flush    = 1'b1;
        start    = 1'b1;
        key_size = 2'd2;
        key_in   = k_new;
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_clear: valid=%b busy=%b err=%b, expected 0 0 0", out_valid, busy, err);
        end
        build_model(k_new, 8);
        start_key(2'd2, k_new);
        collect(100, -1);
    endtask

    task automatic test_async_reset();
        int cnt = 0;
        bit quiet = 1'b1;
        start_key(2'd1, rand256());
        out_ready = 1'b1;
        while (!(out_valid && out_round == 4'd2) && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        #3 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({out_valid, busy, err, out_last} !== 4'b0000 || out_key !== '0 || out_round !== 4'd0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b busy=%b err=%b last=%b round=%0d key=%h, expected all 0",
                     out_valid, busy, err, out_last, out_round, out_key);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0 || out_key !== '0) quiet = 1'b0;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL post_reset_residue: valid=%b busy=%b key=%h, expected 0 0 0", out_valid, busy, out_key);
        end
    endtask

    task automatic test_random();
        logic [255:0] k;
        int           sz;
        for (int it = 0; it < 4; it++) begin
            sz = int'($urandom_range(0, 2));
            k  = rand256();
            build_model(k, 4 + 2 * sz);
            start_key(2'(sz), k);
            collect(70, -1);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_illegal();
        test_start_during_busy();
        test_flush_restart();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
